// File: rtl/ddr_write_arbiter.sv
// Two-client DDR write arbiter.
// Grants one client a whole burst (address plus BEATS data beats).
module ddr_write_arbiter #(
  parameter int BEATS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [30:0]  c0_af_addr_din,
  input  logic         c0_af_wr_en,
  input  logic [127:0] c0_wdf_din,
  input  logic [15:0]  c0_wdf_mask_din,
  input  logic         c0_wdf_wr_en,
  output logic         c0_af_full,
  output logic         c0_wdf_full,
  input  logic [30:0]  c1_af_addr_din,
  input  logic         c1_af_wr_en,
  input  logic [127:0] c1_wdf_din,
  input  logic [15:0]  c1_wdf_mask_din,
  input  logic         c1_wdf_wr_en,
  output logic         c1_af_full,
  output logic         c1_wdf_full,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  localparam logic [2:0] BMAX = 3'(BEATS);

  state_t     state;
  logic       last;
  logic       addr_done;
  logic [2:0] beats;

  logic       own0;
  logic       own1;
  logic       c0_req;
  logic       c1_req;
  logic       a_acc;
  logic       b_acc;
  logic       done;
  logic       full_beats;
  logic [2:0] beats_nxt;

  // Ownership is masked during reset so nothing leaks to the FIFOs
  assign own0 = (state == OWN0) & ~rst;
  assign own1 = (state == OWN1) & ~rst;

  assign c0_req = c0_af_wr_en | c0_wdf_wr_en;
  assign c1_req = c1_af_wr_en | c1_wdf_wr_en;

  assign full_beats = (beats == BMAX);

  assign a_acc = ((own0 & c0_af_wr_en) |
                  (own1 & c1_af_wr_en)) &
                 ~af_full & ~addr_done;

  assign b_acc = ((own0 & c0_wdf_wr_en) |
                  (own1 & c1_wdf_wr_en)) &
                 ~wdf_full & (beats < BMAX);

  assign beats_nxt = beats + {2'b00, b_acc};

  assign done = (addr_done | a_acc) &
                (beats_nxt == BMAX);

  assign af_wr_en  = a_acc;
  assign wdf_wr_en = b_acc;

  assign grant = {state == OWN1, state == OWN0};

  assign c0_af_full  = own0 ?
                       (af_full | addr_done) : 1'b1;
  assign c0_wdf_full = own0 ?
                       (wdf_full | full_beats) : 1'b1;
  assign c1_af_full  = own1 ?
                       (af_full | addr_done) : 1'b1;
  assign c1_wdf_full = own1 ?
                       (wdf_full | full_beats) : 1'b1;

  // Route the owner's buses to the FIFOs, zero when idle
  always_comb begin
    af_addr_din  = '0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    if (own0) begin
      af_addr_din  = c0_af_addr_din;
      wdf_din      = c0_wdf_din;
      wdf_mask_din = c0_wdf_mask_din;
    end else if (own1) begin
      af_addr_din  = c1_af_addr_din;
      wdf_din      = c1_wdf_din;
      wdf_mask_din = c1_wdf_mask_din;
    end
  end

  // Ownership FSM with round-robin tie break and burst counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      addr_done <= 1'b0;
      beats     <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          addr_done <= 1'b0;
          beats     <= 3'd0;
          if (c0_req & (~c1_req | last))
            state <= OWN0;
          else if (c1_req)
            state <= OWN1;
        end
        OWN0, OWN1: begin
          if (done) begin
            state     <= IDLE;
            last      <= (state == OWN1);
            addr_done <= 1'b0;
            beats     <= 3'd0;
          end else begin
            addr_done <= addr_done | a_acc;
            beats     <= beats_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ddr_write_arbiter.md
# ddr_write_arbiter

Two-client write arbiter between the graphics write masters and the DDR request FIFOs. Client 0 is the line engine, client 1 is the frame filler. Each client drives the standard address-FIFO / write-data-FIFO write port and sees the standard full flags. The arbiter grants one client for one whole burst (one address plus `BEATS` data beats), with round-robin fairness, so bursts from different clients never interleave in the FIFOs.

## Interface
- `BEATS`, default 2: write-data beats per burst (128-bit each); legal values 1–4.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `c0_af_addr_din`, `c1_af_addr_din`  in  31 each  client address.
- `c0_af_wr_en`, `c1_af_wr_en`  in  1 each  client address write request.
- `c0_wdf_din`, `c1_wdf_din`  in  128 each  client write data.
- `c0_wdf_mask_din`, `c1_wdf_mask_din`  in  16 each  client byte mask.
- `c0_wdf_wr_en`, `c1_wdf_wr_en`  in  1 each  client data write request.
- `c0_af_full`, `c1_af_full`  out  1 each  client-side address full (backpressure).
- `c0_wdf_full`, `c1_wdf_full`  out  1 each  client-side data full (backpressure).
- `af_full`, `wdf_full`  in  1 each  full flags from the real FIFOs.
- `af_addr_din`  out  31  address forwarded to the FIFO.
- `af_wr_en`  out  1  address write enable to the FIFO.
- `wdf_din`  out  128  data forwarded to the FIFO.
- `wdf_mask_din`  out  16  mask forwarded to the FIFO.
- `wdf_wr_en`  out  1  data write enable to the FIFO.
- `grant`  out  2  one-hot current owner; 00 = idle.

## Operation
- **States:** IDLE, OWN0, OWN1. `grant` = {state==OWN1, state==OWN0}.
- **Client request:** `cN_req = cN_af_wr_en | cN_wdf_wr_en`. A client holds its enables while it sees full, per normal FIFO semantics.
- **IDLE:**
  - Only c0 requesting → OWN0. Only c1 requesting → OWN1.
  - Both requesting → the client that did not own the previous burst wins.
  - After reset, c0 wins the first tie.
  - `last` register records the most recent owner; reset value 1, so c0 wins the first tie.
- **OWNn, per-burst counters:**
  - `addr_done` (1 bit) sets when an address is accepted.
  - `beats` (3 bits) increments when a data beat is accepted.
  - Address accepted = `cN_af_wr_en & ~af_full & ~addr_done`.
  - Beat accepted = `cN_wdf_wr_en & ~wdf_full & (beats < BEATS)`.
  - Address and data may arrive in any order; they may also arrive in the same cycle.
- **Forwarding (combinational from state and counters):**
  - `af_wr_en` = address accepted; `wdf_wr_en` = beat accepted.
  - Data and address buses are muxed from the owner. In IDLE they are driven 0.
- **Client full flags:**
  - Owner: `cN_af_full = af_full | addr_done`; `cN_wdf_full = wdf_full | (beats == BEATS)`.
  - Non-owner, and both clients in IDLE: full flags = 1.
- **Completion:** when `addr_done` and `beats == BEATS` both hold after the current cycle's accepts, on that edge:
  - go to IDLE, set `last` to the owner, clear the counters.
- **Abandonment:** an owner with no completed burst keeps the grant indefinitely. There is no timeout; clients must finish bursts they start.
- **Reset:** state IDLE, counters 0, `last`=1. All FIFO write enables are 0 and all client full flags are 1 in the reset cycle and the cycle after. A burst cut short by reset is discarded; the FIFO reset is coupled to the same `rst`.

## Timing
- **Grant latency:**
  - Request first visible in IDLE in cycle N.
  - Ownership from cycle N+1; the owner's full flags track `af_full`/`wdf_full` combinationally from N+1.
  - Earliest FIFO write at N+1.
- **Burst length:** `max(1, BEATS)` cycles when the FIFOs are not full and the client drives both enables with no gaps. BEATS=2 → 2 cycles (address+beat0, then beat1).
- **Bubble:** exactly one IDLE cycle between consecutive bursts, even when the same client or the other client requests immediately.
- **FIFO stall:** `af_full`/`wdf_full` asserted mid-burst block only the affected write. Counters hold and ownership is retained.
- **Simultaneous events:** address and final beat accepted in the same cycle complete the burst that cycle.

## Test plan
- **Reset:** hold `rst` 3 cycles with both clients requesting → `grant`=00, `af_wr_en`=`wdf_wr_en`=0, all client full flags=1. c0 owns from the first cycle after release + 1.
- **Single c0 burst:** `addr`=0x0012_3400, data A then B, both enables high.
  - Cycle 1: `af_wr_en`=1, `wdf_wr_en`=1 (data A). Cycle 2: `wdf_wr_en`=1 (data B).
  - Cycle 3: IDLE; `c0_af_full`=1.
- **Contention, both requesting continuously:** bursts alternate c0, c1, c0, c1, each separated by one IDLE cycle. No FIFO write ever carries the non-owner's address or data.
- **Data before address:** c1 drives 2 beats, then its address 3 cycles later → 2 `wdf_wr_en` pulses, then 1 `af_wr_en` pulse. Grant is released after the address is accepted. A 3rd beat attempt sees `c1_wdf_full`=1.
- **Backpressure:** `wdf_full`=1 for 4 cycles mid-burst → no `wdf_wr_en` during those cycles. `c0_wdf_full`=1 during them, grant is held, and the burst completes when `wdf_full` drops.
- **Reset mid-burst:** after address and 1 beat, pulse `rst` → next cycle `grant`=00 and counters are 0. A fresh c0 burst then needs a full address plus 2 beats.
